viterbi_hard_decoder: RTL

Hard-decision Viterbi decoder for the team's rate-1/2, constraint-length-3 convolutional code (generators G0 = 3'b111, G1 = 3'b101). It sits directly downstream of the convolutional encoder and the channel model. It accepts one 2-bit code symbol per cycle for a fixed-length frame, runs add-compare-select (ACS) over 4 trellis states, and traces back once per frame. It then presents the recovered N_SYM+2 message bits in parallel, together with the winning path metric.

---
 rtl/viterbi_pkg.sv | 32 +++
 rtl/viterbi_acs.sv | 26 ++
 rtl/viterbi_hard_decoder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// Shared constants, FSM encoding and code-model helpers for the hard-decision Viterbi decoder.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package viterbi_pkg;

    // Generator taps over the shift register {u[k+2], u[k+1], u[k]}
    localparam logic [2:0] G0 = 3'b111;
    localparam logic [2:0] G1 = 3'b101;
    localparam int NUM_STATES = 4;

    typedef enum logic [1:0] {
        ACS   = 2'd0,
        FIND  = 2'd1,
        TRACE = 2'd2,
        DONE  = 2'd3
    } vit_state_e;

    // Code symbol {c1, c0} emitted when bit b enters from state prev_state = {a1, a0}
    function automatic logic [1:0] expected_sym(input logic [1:0] prev_state, input logic b);
        logic [2:0] sr;
        sr = {b, prev_state};
        return {^(sr & G1), ^(sr & G0)};
    endfunction

    // Hamming distance between two 2-bit symbols (0..2)
    function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] b);
        logic [1:0] x;
        x = a ^ b;
        return {1'b0, x[1]} + {1'b0, x[0]};
    endfunction

endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state: picks the cheaper of its two predecessors.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is registered.
module viterbi_acs #(
    parameter int PM_W = 7
) (
    input  logic [PM_W-1:0] pm_a0,   // metric of predecessor with a0 = 0
    input  logic [PM_W-1:0] pm_a1,   // metric of predecessor with a0 = 1
    input  logic [1:0]      bm_a0,
    input  logic [1:0]      bm_a1,
    output logic [PM_W-1:0] pm_new,
    output logic            dec
);

    logic [PM_W-1:0] sum_a0;
    logic [PM_W-1:0] sum_a1;

    // Tie goes to the a0 = 0 predecessor, so only a strictly smaller sum selects a0 = 1
    always_comb begin
        sum_a0 = pm_a0 + PM_W'(bm_a0);
        sum_a1 = pm_a1 + PM_W'(bm_a1);
        dec    = (sum_a1 < sum_a0);
        pm_new = dec ? sum_a1 : sum_a0;
    end

endmodule

// File: rtl/viterbi_hard_decoder.sv
// Rate-1/2 K=3 hard-decision Viterbi decoder: ACS per symbol, one traceback per frame.
// Latency: result valid N_SYM+2 cycles after the last symbol handshake.
// Backpressure: sym_ready low outside ACS; result held until out_ready, no new symbols taken meanwhile.
module viterbi_hard_decoder
    import viterbi_pkg::*;
#(
    parameter int N_SYM = 30,
    parameter int PM_W  = 7
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         sym,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic [N_SYM+1:0]   out_bits,
    output logic [PM_W-1:0]    out_metric,
    output logic               out_valid,
    input  logic               out_ready
);

    localparam int CNT_W = $clog2(N_SYM);
    localparam logic [CNT_W-1:0] LAST_K = CNT_W'(N_SYM - 1);

    vit_state_e              state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [PM_W-1:0]         pm_q [NUM_STATES];
    logic [PM_W-1:0]         pm_d [NUM_STATES];
    logic [1:0]              tb_state_q, tb_state_d;
    logic [N_SYM+1:0]        bits_q, bits_d;
    logic [PM_W-1:0]         metric_q, metric_d;
    logic [NUM_STATES-1:0]   surv_q [N_SYM];
    logic [NUM_STATES-1:0]   surv_d [N_SYM];

    logic                    acs_en;
    logic                    find_en;
    logic                    trace_en;
    logic                    clear_en;
    logic                    trace_dec;
    logic [1:0]              best;
    logic [PM_W-1:0]         acs_pm [NUM_STATES];
    logic [NUM_STATES-1:0]   acs_dec;

    // One ACS per next state {b, a1}; its predecessors are {a1, 0} and {a1, 1}
    for (genvar ns = 0; ns < NUM_STATES; ns++) begin : g_acs
        localparam logic [1:0] NS = 2'(ns);
        localparam logic [1:0] P0 = {NS[0], 1'b0};
        localparam logic [1:0] P1 = {NS[0], 1'b1};

        logic [1:0] bm_a0;
        logic [1:0] bm_a1;

        assign bm_a0 = hamming2(sym, expected_sym(P0, NS[1]));
        assign bm_a1 = hamming2(sym, expected_sym(P1, NS[1]));

        viterbi_acs #(.PM_W(PM_W)) u_acs (
            .pm_a0  (pm_q[P0]),
            .pm_a1  (pm_q[P1]),
            .bm_a0  (bm_a0),
            .bm_a1  (bm_a1),
            .pm_new (acs_pm[ns]),
            .dec    (acs_dec[ns])
        );
    end

    assign trace_dec  = surv_q[cnt_q][tb_state_q];
    assign acs_en     = sym_valid && sym_ready;
    assign clear_en   = out_valid && out_ready;
    assign out_bits   = bits_q;
    assign out_metric = metric_q;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACS;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: symbols, one argmin cycle, N_SYM traceback cycles, hold result
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACS:     if (sym_valid && cnt_q == LAST_K) state_d = FIND;
            FIND:    state_d = TRACE;
            TRACE:   if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready) state_d = ACS;
            default: state_d = ACS;
        endcase
    end

    // FSM outputs and per-state datapath enables
    always_comb begin
        sym_ready = 1'b0;
        out_valid = 1'b0;
        find_en   = 1'b0;
        trace_en  = 1'b0;
        case (state_q)
            ACS:     sym_ready = 1'b1;
            FIND:    find_en   = 1'b1;
            TRACE:   trace_en  = 1'b1;
            DONE:    out_valid = 1'b1;
            default: sym_ready = 1'b0;
        endcase
    end

    // Datapath: metrics and counter in ACS, argmin in FIND, walk survivors backwards in TRACE
    always_comb begin
        cnt_d      = cnt_q;
        pm_d       = pm_q;
        tb_state_d = tb_state_q;
        bits_d     = bits_q;
        metric_d   = metric_q;
        best       = 2'd0;

        if (acs_en) begin
            pm_d = acs_pm;
            // Counter parks on the last index so traceback starts from row N_SYM-1
            if (cnt_q != LAST_K) cnt_d = cnt_q + 1'b1;
        end

        if (find_en) begin
            for (int s = 1; s < NUM_STATES; s++) begin
                if (pm_q[s] < pm_q[best]) best = 2'(s);
            end
            tb_state_d      = best;
            bits_d[N_SYM+1] = best[1];
            bits_d[N_SYM]   = best[0];
            metric_d        = pm_q[best];
        end

        if (trace_en) begin
            bits_d[cnt_q] = trace_dec;
            tb_state_d    = {tb_state_q[0], trace_dec};
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end

        // Start state is unknown, so every frame begins with all metrics equal
        if (clear_en) begin
            cnt_d = '0;
            for (int s = 0; s < NUM_STATES; s++) pm_d[s] = '0;
        end
    end

    // Survivor row k records every state's decision bit for symbol k
    always_comb begin
        surv_d = surv_q;
        if (acs_en) surv_d[cnt_q] = acs_dec;
    end

    // Survivor memory has no reset: every row is rewritten before traceback reads it
    always_ff @(posedge clk) begin
        surv_q <= surv_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            tb_state_q <= '0;
            bits_q     <= '0;
            metric_q   <= '0;
            for (int s = 0; s < NUM_STATES; s++) pm_q[s] <= '0;
        end else begin
            cnt_q      <= cnt_d;
            tb_state_q <= tb_state_d;
            bits_q     <= bits_d;
            metric_q   <= metric_d;
            pm_q       <= pm_d;
        end
    end

endmodule
